mru_victim_ctl: RTL and testbench

- Controller that reads and maintains the 4-way MRU replacement bits held in the 8192-entry bit regfile of the 1 MB L1.
- Two operations:
  - Hit update: marks the accessed way as most recently used.
  - Victim select: on a miss, picks the way to replace, then marks it as used.
- Normalizes a set once all four MRU bits would be 1.
- Sits between the tag/miss pipeline and the bit regfile. It is the sole driver of that regfile's read address and write port.

---
 rtl/mru_victim_if.sv | 34 +++
 rtl/mru_victim_ctl.sv | 212 +++++++++++++++++++++
 tb/tb_mru_victim_ctl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mru_victim_if.sv
// Request/response handshake plus MRU bit-regfile port bundle for mru_victim_ctl.
// slave  = controller view, master = requester / regfile owner view.
interface mru_victim_if #(
  parameter int IDX_W = 13
);
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [IDX_W-1:0] req_set;
  logic [3:0]       req_way;
  logic [3:0]       req_vbits;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_way;
  logic             rsp_norm;
  logic [IDX_W-1:0] mru_ra;
  logic [3:0]       mru_rd;
  logic [IDX_W-1:0] mru_wa;
  logic [3:0]       mru_way_hit;
  logic             mru_wr;
  logic             mru_in;

  modport slave (
    input  req_valid, req_op, req_set, req_way, req_vbits, rsp_ready, mru_rd,
    output req_ready, rsp_valid, rsp_way, rsp_norm,
           mru_ra, mru_wa, mru_way_hit, mru_wr, mru_in
  );

  modport master (
    output req_valid, req_op, req_set, req_way, req_vbits, rsp_ready, mru_rd,
    input  req_ready, rsp_valid, rsp_way, rsp_norm,
           mru_ra, mru_wa, mru_way_hit, mru_wr, mru_in
  );
endinterface

// File: rtl/mru_victim_ctl.sv
// MRU replacement-bit controller for the 4-way L1: hit update and victim
// selection, with set normalization when all four MRU bits would be set.
// Optional statistics counters are built only when MRU_STATS_EN is defined;
// otherwise the stat ports are tied to zero.
module mru_victim_ctl #(
  parameter int SETS  = 8192,
  parameter int IDX_W = 13,
  parameter int WAYS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  mru_victim_if.slave bus,
  output logic [31:0] stat_victims,
  output logic [31:0] stat_invalid,
  output logic [31:0] stat_norms
);

  if (WAYS != 4) begin : g_bad_ways
    $error("mru_victim_ctl supports only WAYS == 4");
  end
  if (IDX_W != $clog2(SETS)) begin : g_bad_idx
    $error("mru_victim_ctl requires IDX_W == clog2(SETS)");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_SET,
    S_CLEAR,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_op;
  logic [IDX_W-1:0] r_set;
  logic [3:0]       r_way;
  logic [3:0]       r_vbits;
  logic [3:0]       r_vec;
  logic [3:0]       r_sel;
  logic             r_norm;
  logic             r_inv;
  logic [1:0]       r_cnt;
  logic [1:0]       r_clr_n;

  logic [3:0]       w_victim;
  logic             w_inv;
  logic [3:0]       w_sel;
  logic             w_norm;
  logic [1:0]       w_cnt_first;
  logic [1:0]       w_cnt_next;
  logic             w_rsp_fire;

  // One-hot of the lowest clear bit; zero when all bits are set.
  function automatic logic [3:0] lowest_zero(input logic [3:0] v);
    logic [3:0] t;
    t = v + 4'd1;
    return ~v & t;
  endfunction

  // Clear-walk step: advance past the way that must keep its MRU bit.
  function automatic logic [1:0] skip_sel(input logic [1:0] c, input logic [3:0] sel);
    logic [1:0] r;
    r = c;
    if (sel[r]) r = r + 2'd1;
    return r;
  endfunction

  // Victim choice: invalid ways first, then non-MRU ways, else way 0.
  always_comb begin
    w_victim = 4'b0001;
    w_inv    = 1'b0;
    if (r_vbits != 4'hF) begin
      w_inv    = 1'b1;
      w_victim = lowest_zero(r_vbits);
    end else if (bus.mru_rd != 4'hF) begin
      w_victim = lowest_zero(bus.mru_rd);
    end
  end

  assign w_sel       = r_op ? w_victim : r_way;
  assign w_norm      = ((r_vec | r_sel) == 4'hF);
  assign w_cnt_first = skip_sel(2'd0, r_sel);
  assign w_cnt_next  = skip_sel(r_cnt + 2'd1, r_sel);
  assign w_rsp_fire  = (r_state == S_RESP) && bus.rsp_ready;

  // Regfile addresses follow the latched set for the whole operation.
  assign bus.mru_ra  = r_set;
  assign bus.mru_wa  = r_set;
  assign bus.rsp_way  = r_sel;
  assign bus.rsp_norm = r_norm;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and per-state handshake / regfile write controls.
  always_comb begin
    w_state_next    = r_state;
    bus.req_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.mru_wr      = 1'b0;
    bus.mru_in      = 1'b0;
    bus.mru_way_hit = 4'b0000;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        w_state_next = S_SET;
      end
      S_SET: begin
        bus.mru_wr      = 1'b1;
        bus.mru_in      = 1'b1;
        bus.mru_way_hit = r_sel;
        w_state_next    = w_norm ? S_CLEAR : S_RESP;
      end
      S_CLEAR: begin
        bus.mru_wr      = 1'b1;
        bus.mru_way_hit = 4'b0001 << r_cnt;
        if (r_clr_n == 2'd2) w_state_next = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request latch, lookup capture, normalization flag and clear-walk counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= 1'b0;
      r_set   <= '0;
      r_way   <= 4'b0000;
      r_vbits <= 4'b0000;
      r_vec   <= 4'b0000;
      r_sel   <= 4'b0000;
      r_norm  <= 1'b0;
      r_inv   <= 1'b0;
      r_cnt   <= 2'd0;
      r_clr_n <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_op    <= bus.req_op;
            r_set   <= bus.req_set;
            r_way   <= bus.req_way;
            r_vbits <= bus.req_vbits;
          end
        end
        S_LOOKUP: begin
          r_vec <= bus.mru_rd;
          r_sel <= w_sel;
          r_inv <= r_op & w_inv;
        end
        S_SET: begin
          r_norm  <= w_norm;
          r_cnt   <= w_cnt_first;
          r_clr_n <= 2'd0;
        end
        S_CLEAR: begin
          r_cnt   <= w_cnt_next;
          r_clr_n <= r_clr_n + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef MRU_STATS_EN
  logic [31:0] r_stat_victims;
  logic [31:0] r_stat_invalid;
  logic [31:0] r_stat_norms;

  // Saturating event counters, bumped when a response is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_victims <= '0;
      r_stat_invalid <= '0;
      r_stat_norms   <= '0;
    end else if (w_rsp_fire) begin
      if (r_op && (r_stat_victims != '1))          r_stat_victims <= r_stat_victims + 32'd1;
      if (r_op && r_inv && (r_stat_invalid != '1)) r_stat_invalid <= r_stat_invalid + 32'd1;
      if (r_norm && (r_stat_norms != '1))          r_stat_norms   <= r_stat_norms + 32'd1;
    end
  end

  assign stat_victims = r_stat_victims;
  assign stat_invalid = r_stat_invalid;
  assign stat_norms   = r_stat_norms;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_rsp_fire ^ r_inv;
  assign stat_victims   = 32'd0;
  assign stat_invalid   = 32'd0;
  assign stat_norms     = 32'd0;
`endif

`ifndef SYNTHESIS
  // A hit update must name exactly one way.
  a_hit_way_onehot : assert property (@(posedge clk) disable iff (reset)
    (bus.req_valid && bus.req_ready && !bus.req_op) |-> $onehot(bus.req_way));
`endif

endmodule

// File: tb/tb_mru_victim_ctl.sv
// Directed bench for mru_victim_ctl with a behavioural MRU bit regfile.
module tb_mru_victim_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] stat_victims;
  logic [31:0] stat_invalid;
  logic [31:0] stat_norms;

  int total = 0;
  int bad   = 0;

  mru_victim_if #(.IDX_W(13)) bus ();

  mru_victim_ctl #(.SETS(8192), .IDX_W(13), .WAYS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .stat_victims (stat_victims),
    .stat_invalid (stat_invalid),
    .stat_norms   (stat_norms)
  );

  always #5 clk = ~clk;

  // Regfile model: combinational read, bit-select write; the bench pokes
  // contents through the same process before each operation.
  logic [3:0]  mem [0:8191];
  logic        poke_en = 1'b0;
  logic [12:0] poke_set = '0;
  logic [3:0]  poke_val = '0;
  int          wr_total = 0;
  logic [15:0] clr_seq = '0;

  assign bus.mru_rd = mem[bus.mru_ra];

  always @(posedge clk) begin
    if (poke_en) mem[poke_set] <= poke_val;
    if (bus.mru_wr) begin
      for (int k = 0; k < 4; k++)
        if (bus.mru_way_hit[k]) mem[bus.mru_wa][k] <= bus.mru_in;
      wr_total <= wr_total + 1;
      if (!bus.mru_in) clr_seq <= {clr_seq[11:0], bus.mru_way_hit};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [12:0] s, input logic [3:0] v);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_set = s;
    poke_val = v;
    @(negedge clk);
    poke_en  = 1'b0;
  endtask

  // Present one request; returns at the negedge after the accepting edge.
  task automatic send(input logic op, input logic [12:0] s, input logic [3:0] way,
                      input logic [3:0] vb);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_set   = s;
    bus.req_way   = way;
    bus.req_vbits = vb;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Edges from acceptance (counted as 1) until rsp_valid is seen.
  task automatic wait_rsp(output int edges);
    edges = 1;
    while (!bus.rsp_valid && edges < 30) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic op, input logic [12:0] s,
                        input logic [3:0] way, input logic [3:0] vb,
                        input int exp_edges, input logic [3:0] exp_way,
                        input logic exp_norm, input logic [3:0] exp_vec, input int exp_wr);
    int edges;
    int w0;
    w0 = wr_total;
    send(op, s, way, vb);
    wait_rsp(edges);
    check({tag, "_latency"}, edges, exp_edges);
    check({tag, "_rsp_way"}, {28'd0, bus.rsp_way}, {28'd0, exp_way});
    check({tag, "_rsp_norm"}, {31'd0, bus.rsp_norm}, {31'd0, exp_norm});
    @(negedge clk);
    check({tag, "_ready_after"}, {31'd0, bus.req_ready}, 32'd1);
    check({tag, "_vec"}, {28'd0, mem[s]}, {28'd0, exp_vec});
    check({tag, "_writes"}, wr_total - w0, exp_wr);
  endtask

  initial begin
    int edges;
    int w0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_set   = '0;
    bus.req_way   = '0;
    bus.req_vbits = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_way", {28'd0, bus.rsp_way}, 32'd0);
    check("rst_rsp_norm", {31'd0, bus.rsp_norm}, 32'd0);
    check("rst_mru_wr", {31'd0, bus.mru_wr}, 32'd0);
    check("rst_mru_in", {31'd0, bus.mru_in}, 32'd0);
    check("rst_way_hit", {28'd0, bus.mru_way_hit}, 32'd0);
    check("rst_ra", {19'd0, bus.mru_ra}, 32'd0);
    check("rst_wa", {19'd0, bus.mru_wa}, 32'd0);

    // Victim, all valid, empty vector -> way 0
    poke(13'h0005, 4'b0000);
    run_op("vic_basic", 1'b1, 13'h0005, 4'b0000, 4'hF, 3, 4'b0001, 1'b0, 4'b0001, 1);
    $display("op vic_basic set=0005 done");

    // Victim with an invalid way -> invalid way wins
    poke(13'h0123, 4'b0000);
    run_op("vic_invalid", 1'b1, 13'h0123, 4'b0000, 4'b1011, 3, 4'b0100, 1'b0, 4'b0100, 1);
    $display("op vic_invalid set=0123 done");

    // Hit that fills the vector -> normalization clears ways 0,1,2
    poke(13'h1FFF, 4'b0111);
    run_op("hit_norm", 1'b0, 13'h1FFF, 4'b1000, 4'h0, 6, 4'b1000, 1'b1, 4'b1000, 4);
    check("hit_norm_clr_order", {20'd0, clr_seq[11:0]}, {20'd0, 12'b0001_0010_0100});
    $display("op hit_norm set=1FFF done");

    // Victim, lowest non-MRU way
    poke(13'h0042, 4'b1010);
    run_op("vic_mru", 1'b1, 13'h0042, 4'b0000, 4'hF, 3, 4'b0001, 1'b0, 4'b1011, 1);
    $display("op vic_mru set=0042 done");

    // Victim on a saturated vector -> way 0, normalize to 0001
    poke(13'h00AA, 4'b1111);
    run_op("vic_full", 1'b1, 13'h00AA, 4'b0000, 4'hF, 6, 4'b0001, 1'b1, 4'b0001, 4);
    check("vic_full_clr_order", {20'd0, clr_seq[11:0]}, {20'd0, 12'b0010_0100_1000});
    $display("op vic_full set=00AA done");

    // Response back-pressure
    poke(13'h0007, 4'b0110);
    bus.rsp_ready = 1'b0;
    send(1'b1, 13'h0007, 4'b0000, 4'hF);
    wait_rsp(edges);
    check("stall_latency", edges, 3);
    w0 = wr_total;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("stall_rsp_way", {28'd0, bus.rsp_way}, {28'd0, 4'b0001});
      check("stall_rsp_norm", {31'd0, bus.rsp_norm}, 32'd0);
      check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("stall_mru_wr", {31'd0, bus.mru_wr}, 32'd0);
    end
    check("stall_no_writes", wr_total - w0, 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release_ready", {31'd0, bus.req_ready}, 32'd1);
    check("stall_vec", {28'd0, mem[13'h0007]}, {28'd0, 4'b0111});
    $display("op stall set=0007 done");

`ifdef MRU_STATS_EN
    check("stat_victims", stat_victims, 32'd5);
    check("stat_invalid", stat_invalid, 32'd1);
    check("stat_norms", stat_norms, 32'd2);
`else
    check("stat_victims_tied", stat_victims, 32'd0);
    check("stat_invalid_tied", stat_invalid, 32'd0);
    check("stat_norms_tied", stat_norms, 32'd0);
`endif

    // Reset in the second CLEAR cycle
    poke(13'h0100, 4'b1110);
    send(1'b0, 13'h0100, 4'b0001, 4'h0);
    repeat (3) @(negedge clk);
    check("mid_clear_wr", {31'd0, bus.mru_wr}, 32'd1);
    check("mid_clear_way", {28'd0, bus.mru_way_hit}, {28'd0, 4'b0100});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("abort_mru_wr", {31'd0, bus.mru_wr}, 32'd0);
    $display("op abort set=0100 done");
    // Partial set 1001 left behind; next victim takes way 1
    run_op("post_abort", 1'b1, 13'h0100, 4'b0000, 4'hF, 3, 4'b0010, 1'b0, 4'b1011, 1);
    $display("op post_abort set=0100 done");

`ifdef MRU_STATS_EN
    check("stat_victims_after_rst", stat_victims, 32'd1);
    check("stat_norms_after_rst", stat_norms, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
